// File: rtl/dc_seq.sv
// DC303 microsequencer: registered {AX, microaddress} for the MicROM with branch,
// call/return, PLA dispatch, trap entry and stall. Optional macro DC_SEQ_STACK_EN.
module dc_seq #(
  parameter logic [8:0] RST_ADDR  = 9'h180,
  parameter logic [8:0] TRAP_ADDR = 9'h1C0,
  parameter int         STK_DEPTH = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [8:0] ma_in,
  input  logic [2:0] seq_op,
  input  logic [8:0] sub_tgt,
  input  logic [8:0] pla_addr,
  input  logic       cond,
  input  logic       ax_in,
  input  logic       stall,
  input  logic       trap_req,
  output logic [9:0] a_out,
  output logic       trap_ack,
  output logic [3:0] stk_lvl,
  output logic       stk_err
);

  typedef enum logic [2:0] {
    OP_NEXT = 3'd0,
    OP_BRC  = 3'd1,
    OP_CALL = 3'd2,
    OP_RET  = 3'd3,
    OP_DISP = 3'd4,
    OP_WAIT = 3'd5
  } op_e;

`ifdef DC_SEQ_STACK_EN
  localparam logic [3:0] LVL_MAX = 4'(STK_DEPTH);
  localparam int         IW      = $clog2(STK_DEPTH);
`else
  localparam logic [3:0] LVL_MAX = 4'd1;
`endif

  logic [8:0] ma_q, ma_d;
  logic       ax_q, ax_d;
  logic       ack_q, ack_d;
  logic [3:0] lvl_q, lvl_d;
  logic       err_q, err_d;
  logic       push, pop;
  logic [8:0] top;
  op_e        op;

  // Return storage carries no reset; stk_lvl alone defines what is valid.
`ifdef DC_SEQ_STACK_EN
  logic [8:0]    stk_q [STK_DEPTH];
  logic [3:0]    lvl_m1;
  logic [IW-1:0] wr_idx, rd_idx;

  assign lvl_m1 = lvl_q - 4'd1;
  assign wr_idx = lvl_q[IW-1:0];
  assign rd_idx = lvl_m1[IW-1:0];
  assign top    = stk_q[rd_idx];

  always_ff @(posedge clk) begin
    if (push) stk_q[wr_idx] <= ma_in;
  end
`else
  logic [8:0] ret_q;

  assign top = ret_q;

  always_ff @(posedge clk) begin
    if (push) ret_q <= ma_in;
  end
`endif

  always_comb begin
    ma_d  = ma_q;
    ax_d  = ax_q;
    ack_d = 1'b0;
    lvl_d = lvl_q;
    err_d = err_q;
    push  = 1'b0;
    pop   = 1'b0;
    op    = op_e'(seq_op);
    if (rst_n && !stall) begin
      ax_d = ax_in;
      if (op == OP_DISP && trap_req) begin
        ma_d  = TRAP_ADDR;
        ack_d = 1'b1;
      end else begin
        case (op)
          OP_BRC:  ma_d = {ma_in[8:1], ma_in[0] | cond};
          OP_CALL: begin
            ma_d = sub_tgt;
            if (lvl_q == LVL_MAX) err_d = 1'b1;
            else                  push  = 1'b1;
          end
          OP_RET: begin
            if (lvl_q == 4'd0) begin
              ma_d  = ma_in;
              err_d = 1'b1;
            end else begin
              ma_d = top;
              pop  = 1'b1;
            end
          end
          OP_DISP: ma_d = pla_addr;
          OP_WAIT: begin
            // Holding re-presents the same word, AX included.
            if (cond) ma_d = ma_in;
            else      ax_d = ax_q;
          end
          default: ma_d = ma_in;
        endcase
      end
      if (push)     lvl_d = lvl_q + 4'd1;
      else if (pop) lvl_d = lvl_q - 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ma_q  <= RST_ADDR;
      ax_q  <= 1'b0;
      ack_q <= 1'b0;
      lvl_q <= 4'd0;
      err_q <= 1'b0;
    end else begin
      ma_q  <= ma_d;
      ax_q  <= ax_d;
      ack_q <= ack_d;
      lvl_q <= lvl_d;
      err_q <= err_d;
    end
  end

  assign a_out    = {ax_q, ma_q};
  assign trap_ack = ack_q;
  assign stk_lvl  = lvl_q;
  assign stk_err  = err_q;

endmodule

// File: tb/tb_dc_seq.sv
// Directed vector bench for dc_seq; expectations track DC_SEQ_STACK_EN
// (stack of 4) versus the single return register.
module tb_dc_seq;

`ifdef DC_SEQ_STACK_EN
  localparam int DEP = 4;
`else
  localparam int DEP = 1;
`endif
  localparam bit L2 = (DEP > 1);

  localparam logic [2:0] NEXT = 3'd0, BRC = 3'd1, CALL = 3'd2, RET = 3'd3,
                         DISP = 3'd4, WAITO = 3'd5;

  logic       clk = 1'b0;
  logic       rst_n, cond, ax_in, stall, trap_req;
  logic [8:0] ma_in, sub_tgt, pla_addr;
  logic [2:0] seq_op;
  logic [9:0] a_out;
  logic       trap_ack, stk_err;
  logic [3:0] stk_lvl;

  int checks = 0;
  int errors = 0;

  typedef struct {
    string      name;
    logic       r, s;
    logic [2:0] op;
    logic [8:0] ma, sub, pla;
    logic       c, ax, tr;
    logic [9:0] ea;
    logic       eack;
    logic [3:0] elvl;
    logic       eerr;
  } vec_t;

  vec_t vq[$];

  dc_seq dut (
    .clk(clk), .rst_n(rst_n), .ma_in(ma_in), .seq_op(seq_op), .sub_tgt(sub_tgt),
    .pla_addr(pla_addr), .cond(cond), .ax_in(ax_in), .stall(stall),
    .trap_req(trap_req), .a_out(a_out), .trap_ack(trap_ack), .stk_lvl(stk_lvl),
    .stk_err(stk_err)
  );

  always #5 clk = ~clk;

  task automatic add(input string nm, input logic r, input logic s, input logic [2:0] op,
                     input logic [8:0] ma, input logic [8:0] sub, input logic [8:0] pla,
                     input logic c, input logic ax, input logic tr, input logic [9:0] ea,
                     input logic eack, input logic [3:0] elvl, input logic eerr);
    vec_t v;
    v.name = nm; v.r = r; v.s = s; v.op = op; v.ma = ma; v.sub = sub; v.pla = pla;
    v.c = c; v.ax = ax; v.tr = tr; v.ea = ea; v.eack = eack; v.elvl = elvl; v.eerr = eerr;
    vq.push_back(v);
  endtask

  task automatic apply(input vec_t v);
    rst_n = v.r; stall = v.s; seq_op = v.op; ma_in = v.ma; sub_tgt = v.sub;
    pla_addr = v.pla; cond = v.c; ax_in = v.ax; trap_req = v.tr;
    @(posedge clk);
    #1;
    checks++;
    if ({a_out, trap_ack, stk_lvl, stk_err} !== {v.ea, v.eack, v.elvl, v.eerr}) begin
      errors++;
      $display("FAIL %s: got a_out=%h ack=%b lvl=%0d err=%b, want a_out=%h ack=%b lvl=%0d err=%b",
               v.name, a_out, trap_ack, stk_lvl, stk_err, v.ea, v.eack, v.elvl, v.eerr);
    end
  endtask

  task automatic op1(input string nm, input logic [2:0] op, input logic [8:0] ma,
                     input logic [8:0] sub, input logic [9:0] ea, input logic [3:0] elvl,
                     input logic eerr);
    vec_t v;
    v.name = nm; v.r = 1'b1; v.s = 1'b0; v.op = op; v.ma = ma; v.sub = sub; v.pla = 9'h0;
    v.c = 1'b0; v.ax = 1'b0; v.tr = 1'b0; v.ea = ea; v.eack = 1'b0; v.elvl = elvl; v.eerr = eerr;
    apply(v);
  endtask

  initial begin
    rst_n = 1'b0; stall = 1'b1; seq_op = CALL; ma_in = '0; sub_tgt = '0;
    pla_addr = '0; cond = 1'b0; ax_in = 1'b0; trap_req = 1'b0;

    //   name        r  s  op     ma      sub     pla     c  ax tr  a_out   ack lvl err
    add("rst0",      0, 1, CALL,  9'h000, 9'h000, 9'h000, 0, 0, 0, 10'h180, 0, 0, 0);
    add("rst1",      0, 1, CALL,  9'h000, 9'h000, 9'h000, 0, 0, 0, 10'h180, 0, 0, 0);
    add("next",      1, 0, NEXT,  9'h042, 9'h000, 9'h000, 0, 0, 0, 10'h042, 0, 0, 0);
    add("brc_c1",    1, 0, BRC,   9'h050, 9'h000, 9'h000, 1, 0, 0, 10'h051, 0, 0, 0);
    add("brc_c0",    1, 0, BRC,   9'h050, 9'h000, 9'h000, 0, 0, 0, 10'h050, 0, 0, 0);
    add("call1",     1, 0, CALL,  9'h010, 9'h100, 9'h000, 0, 0, 0, 10'h100, 0, 1, 0);
    add("call2",     1, 0, CALL,  9'h011, 9'h120, 9'h000, 0, 0, 0, 10'h120, 0,
        L2 ? 4'd2 : 4'd1, !L2);
    add("ret1",      1, 0, RET,   9'h1FF, 9'h000, 9'h000, 0, 0, 0,
        L2 ? 10'h011 : 10'h010, 0, L2 ? 4'd1 : 4'd0, !L2);
    add("ret2",      1, 0, RET,   9'h1FF, 9'h000, 9'h000, 0, 0, 0,
        L2 ? 10'h010 : 10'h1FF, 0, 0, !L2);
    add("rst2",      0, 0, NEXT,  9'h000, 9'h000, 9'h000, 0, 0, 0, 10'h180, 0, 0, 0);
    add("rsv6",      1, 0, 3'd6,  9'h0AB, 9'h000, 9'h000, 0, 0, 0, 10'h0AB, 0, 0, 0);
    add("rsv7",      1, 0, 3'd7,  9'h0AC, 9'h000, 9'h000, 1, 0, 0, 10'h0AC, 0, 0, 0);
    add("trap_next", 1, 0, NEXT,  9'h055, 9'h000, 9'h000, 0, 0, 1, 10'h055, 0, 0, 0);
    add("trap_disp", 1, 0, DISP,  9'h1FF, 9'h000, 9'h0A0, 0, 0, 1, 10'h1C0, 1, 0, 0);
    add("ack_drop",  1, 0, NEXT,  9'h066, 9'h000, 9'h000, 0, 0, 0, 10'h066, 0, 0, 0);
    add("disp",      1, 0, DISP,  9'h1FF, 9'h000, 9'h0A0, 0, 0, 0, 10'h0A0, 0, 0, 0);
    add("stall1",    1, 1, CALL,  9'h030, 9'h140, 9'h000, 0, 0, 0, 10'h0A0, 0, 0, 0);
    add("stall2",    1, 1, CALL,  9'h030, 9'h140, 9'h000, 0, 0, 0, 10'h0A0, 0, 0, 0);
    add("stall3",    1, 1, CALL,  9'h030, 9'h140, 9'h000, 0, 0, 0, 10'h0A0, 0, 0, 0);
    add("stall_rel", 1, 0, CALL,  9'h030, 9'h140, 9'h000, 0, 0, 0, 10'h140, 0, 1, 0);
    add("stall_trap",1, 1, DISP,  9'h000, 9'h000, 9'h0B0, 0, 1, 1, 10'h140, 0, 1, 0);
    add("trap_stk",  1, 0, DISP,  9'h000, 9'h000, 9'h0B0, 0, 0, 1, 10'h1C0, 1, 1, 0);
    add("ret_once",  1, 0, RET,   9'h1FF, 9'h000, 9'h000, 0, 0, 0, 10'h030, 0, 0, 0);
    add("wait_hold", 1, 0, WAITO, 9'h070, 9'h000, 9'h000, 0, 1, 0, 10'h030, 0, 0, 0);
    add("wait_hold2",1, 0, WAITO, 9'h070, 9'h000, 9'h000, 0, 1, 0, 10'h030, 0, 0, 0);
    add("wait_go_ax",1, 0, WAITO, 9'h070, 9'h000, 9'h000, 1, 1, 0, 10'h270, 0, 0, 0);
    add("ax_hold",   1, 0, WAITO, 9'h071, 9'h000, 9'h000, 0, 0, 0, 10'h270, 0, 0, 0);
    add("ax_clear",  1, 0, NEXT,  9'h001, 9'h000, 9'h000, 0, 0, 0, 10'h001, 0, 0, 0);
    add("call_pre",  1, 0, CALL,  9'h012, 9'h150, 9'h000, 0, 0, 0, 10'h150, 0, 1, 0);
    add("rst_mid",   0, 0, CALL,  9'h013, 9'h160, 9'h000, 0, 0, 0, 10'h180, 0, 0, 0);
    add("ret_empty", 1, 0, RET,   9'h033, 9'h000, 9'h000, 0, 0, 0, 10'h033, 0, 0, 1);
    add("rst3",      0, 0, NEXT,  9'h000, 9'h000, 9'h000, 0, 0, 0, 10'h180, 0, 0, 0);

    foreach (vq[i]) apply(vq[i]);

    // Overflow: one CALL past capacity, drain LIFO, then RET on empty.
    for (int i = 0; i <= DEP; i++)
      op1("ovf_call", CALL, 9'h020 + 9'(i), 9'h130 + 9'(i), 10'h130 + 10'(i),
          (i < DEP) ? 4'(i + 1) : 4'(DEP), (i == DEP));
    for (int i = 0; i < DEP; i++)
      op1("ovf_ret", RET, 9'h1FF, 9'h000, 10'h020 + 10'(DEP - 1 - i), 4'(DEP - 1 - i), 1'b1);
    op1("ovf_ret_empty", RET, 9'h077, 9'h000, 10'h077, 4'd0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/dc_seq.md
# dc_seq

Microsequencer for the DC303 control chip. It owns the registered 10-bit microaddress that drives the MicROM `a_in` input and selects the next address each cycle from the ROM next-address field, a subroutine target, a return stack, or the PLA dispatch address. It also handles bus stall and instruction-boundary trap entry. It sits between the instruction PLA/bus interface and the MicROM.

## Interface
- `RST_ADDR`, 9'h180: microaddress loaded by reset.
- `TRAP_ADDR`, 9'h1C0: microaddress entered on an accepted trap.
- `STK_DEPTH`, 4: return-stack depth, 2..8; only used with `DC_SEQ_STACK_EN`.

Ports:
- `clk` in 1: single system clock; all state changes on the rising edge.
- `rst_n` in 1: synchronous reset, active low.
- `ma_in` in 9: next-address field from the MicROM word.
- `seq_op` in 3: sequencing opcode decoded from the current microword.
- `sub_tgt` in 9: subroutine entry address for CALL.
- `pla_addr` in 9: dispatch address from the instruction PLA.
- `cond` in 1: branch condition for BRC.
- `ax_in` in 1: AX extension line, latched with each new address.
- `stall` in 1: bus wait; freezes all sequencer state.
- `trap_req` in 1: pending trap or interrupt, level sensitive.
- `a_out` out 10: {AX, microaddress} to MicROM `a_in`.
- `trap_ack` out 1: one-cycle pulse when a trap is taken.
- `stk_lvl` out 4: current return-stack occupancy.
- `stk_err` out 1: sticky overflow/underflow flag.

## Operation
Encoding of `seq_op` and the next microaddress for each:
- 0 NEXT: `ma_in`.
- 1 BRC: {`ma_in`[8:1], `ma_in`[0] | `cond`}.
- 2 CALL: push `ma_in`, go to `sub_tgt`.
- 3 RET: pop top of stack, go there.
- 4 DISP: `pla_addr`, or `TRAP_ADDR` if `trap_req`=1.
- 5 WAIT: hold the current address until `cond`=1, then `ma_in`.
- 6 and 7: reserved, treated as NEXT.

Selection priority, highest first:
1. `rst_n`=0
2. `stall`=1
3. Trap at DISP
4. `seq_op`

Rules:
- `a_out`[9] is registered from `ax_in` together with the new address bits; it holds during stall and WAIT-hold.
- Trap entry happens only on DISP, i.e. at an instruction boundary. `trap_req` on any other op is ignored, with no queueing beyond the level itself. A taken trap does not touch the stack.
- CALL with the stack full: the push is dropped, the target is still taken, `stk_err` is set.
- RET with the stack empty: go to `ma_in`, `stk_err` is set, `stk_lvl` stays 0.
- `stk_err` clears only on reset.
- The stack is LIFO. `stk_lvl` counts 0..`STK_DEPTH` and never wraps.

## Timing
- Reset, synchronous and registered at the next edge with `rst_n`=0:
  - `a_out` = {1'b0, `RST_ADDR`}
  - `trap_ack`=0, `stk_lvl`=0, `stk_err`=0
  - Stack contents are don't-care.
- `rst_n` low in the middle of a CALL, WAIT or trap: reset wins and the stack is emptied.
- Latency: the address chosen in cycle n appears on `a_out` after edge n+1. The MicROM is combinational, so `ma_in`/`seq_op` for that address are valid in cycle n+1.
- `stall`=1 at an edge: `a_out`, stack, `stk_lvl` and `stk_err` are unchanged and `trap_ack`=0. Ops are re-evaluated when `stall` drops.
- `trap_ack` is high for exactly the cycle after the edge that loads `TRAP_ADDR`.
- WAIT with `cond`=0 re-presents the same address every cycle indefinitely.
- CALL followed immediately by RET returns to the pushed `ma_in` with net stack change 0.

## Configuration
- `DC_SEQ_STACK_EN` defined:
  - Return stack of `STK_DEPTH` entries.
  - `stk_lvl` counts 0..`STK_DEPTH`.
- `DC_SEQ_STACK_EN` undefined:
  - Single return register; `STK_DEPTH` is ignored.
  - `stk_lvl` ∈ {0,1}.
  - A second CALL without RET sets `stk_err` and keeps the first return address.

## Test plan
- Reset:
  - Hold `rst_n`=0 two cycles with `seq_op`=CALL, `stall`=1.
  - Release, and `a_out`=10'h180.
  - `stk_lvl`=0, `stk_err`=0, `trap_ack`=0.
- Branch:
  - From NEXT, present `ma_in`=9'h042, then BRC with `ma_in`=9'h050, `cond`=1.
  - `a_out` goes 10'h042, then 10'h051.
  - With `cond`=0 the second step gives 10'h050.
- Nested calls:
  - CALL(`ma_in`=9'h010, `sub_tgt`=9'h100), then CALL(9'h011, 9'h120).
  - Then RET, RET.
  - `a_out` sequence 10'h100, 10'h120, 10'h011, 10'h010; `stk_lvl` 1,2,1,0.
- Overflow:
  - 5 CALLs with `STK_DEPTH`=4 (stack build), or 2 CALLs with the macro off.
  - `stk_err`=1 and `stk_lvl` saturates.
  - A subsequent RET on empty goes to `ma_in` with `stk_err` still 1.
- Trap:
  - `trap_req`=1 during NEXT: ignored.
  - Then DISP with `pla_addr`=9'h0A0: `a_out`=10'h1C0 and `trap_ack` pulses one cycle.
  - Same with `trap_req`=0: `a_out`=10'h0A0.
- Stall/AX/WAIT:
  - `stall`=1 for 3 cycles during CALL: `a_out` and `stk_lvl` are frozen, and the push happens once after release.
  - WAIT with `cond`=0 holds the address.
  - `ax_in`=1 on a load gives `a_out`[9]=1.
